// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file sequencer: default widths,
// the FSM state encoding and the hard-wired zero register index.
package regfile_pkg;

  localparam int REGSEQ_WIDTH   = 16;
  localparam int REGSEQ_REGBITS = 4;

  // r0 always reads as zero, so write-back to it is dropped
  localparam int REG_ZERO = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WAIT = 3'd3,
    ST_WB   = 3'd4
  } regseq_state_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Bundle of every non-clock/reset signal around the sequencer: the request
// port from decode, the register-file port and the execution-unit handshake.
// master = the sequencer, slave = everything it talks to.
interface regfile_sequencer_if
  import regfile_pkg::*;
#(
  parameter int WIDTH   = REGSEQ_WIDTH,
  parameter int REGBITS = REGSEQ_REGBITS
) ();

  // request from decode
  logic               req_valid;
  logic               req_ready;
  logic [REGBITS-1:0] req_rsrc;
  logic [REGBITS-1:0] req_rdest;
  logic               req_wb;
  logic               req_imm_sel;
  logic [WIDTH-1:0]   req_imm;

  // register-file port
  logic [REGBITS-1:0] ra1;
  logic [REGBITS-1:0] ra2;
  logic [WIDTH-1:0]   rd1;
  logic [WIDTH-1:0]   rd2;
  logic               regwrite;
  logic [WIDTH-1:0]   wd;

  // execution unit
  logic               exe_valid;
  logic               exe_ready;
  logic [WIDTH-1:0]   exe_a;
  logic [WIDTH-1:0]   exe_b;
  logic               res_valid;
  logic [WIDTH-1:0]   res_data;

  // completion
  logic               done;

  modport master (
    input  req_valid, req_rsrc, req_rdest, req_wb, req_imm_sel, req_imm,
    input  rd1, rd2, exe_ready, res_valid, res_data,
    output req_ready, ra1, ra2, regwrite, wd, exe_valid, exe_a, exe_b, done
  );

  modport slave (
    output req_valid, req_rsrc, req_rdest, req_wb, req_imm_sel, req_imm,
    output rd1, rd2, exe_ready, res_valid, res_data,
    input  req_ready, ra1, ra2, regwrite, wd, exe_valid, exe_a, exe_b, done
  );

endinterface

// File: rtl/regfile_sequencer.sv
// Register-file sequencer: reads Rdest/Rsrc, hands operands to the execution
// unit, waits for its result and optionally writes it back to Rdest.
// One operation in flight, five cycles minimum per operation.
// Optional feature macro: REGSEQ_IMM_EN (operand B may be an immediate).
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int WIDTH   = REGSEQ_WIDTH,
  parameter int REGBITS = REGSEQ_REGBITS
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'(ST_IDLE);
  localparam logic [2:0] S_READ = 3'(ST_READ);
  localparam logic [2:0] S_EXEC = 3'(ST_EXEC);
  localparam logic [2:0] S_WAIT = 3'(ST_WAIT);
  localparam logic [2:0] S_WB   = 3'(ST_WB);

  logic [2:0]         state_r;
  logic [REGBITS-1:0] ra1_r;      // latched rsrc
  logic [REGBITS-1:0] ra2_r;      // latched rdest, also the write address
  logic               wb_r;
  logic               regwrite_r;
  logic [WIDTH-1:0]   wd_r;
  logic               exe_valid_r;
  logic [WIDTH-1:0]   exe_a_r;
  logic [WIDTH-1:0]   exe_b_r;
  logic               done_r;
  logic [WIDTH-1:0]   operand_b_s;
  logic               accept_s;

  assign accept_s = (state_r == S_IDLE) && bus.req_valid;

`ifdef REGSEQ_IMM_EN
  logic             imm_sel_r;
  logic [WIDTH-1:0] imm_r;

  // Latch the immediate selection together with the rest of the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_sel_r <= 1'b0;
      imm_r     <= '0;
    end else if (accept_s) begin
      imm_sel_r <= bus.req_imm_sel;
      imm_r     <= bus.req_imm;
    end
  end

  // Operand B is the immediate when selected, otherwise the Rsrc value
  always_comb begin
    operand_b_s = bus.rd1;
    if (imm_sel_r) begin
      operand_b_s = imm_r;
    end else begin
      operand_b_s = bus.rd1;
    end
  end
`else
  logic unused_imm_s;
  assign unused_imm_s = ^{bus.req_imm_sel, bus.req_imm};

  // Without immediates operand B is always the Rsrc value
  always_comb begin
    operand_b_s = bus.rd1;
  end
`endif

  // Sequencer FSM with registered register-file and execution-unit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      ra1_r       <= '0;
      ra2_r       <= '0;
      wb_r        <= 1'b0;
      regwrite_r  <= 1'b0;
      wd_r        <= '0;
      exe_valid_r <= 1'b0;
      exe_a_r     <= '0;
      exe_b_r     <= '0;
      done_r      <= 1'b0;
    end else begin
      // single-cycle strobes
      regwrite_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.req_valid) begin
            ra1_r   <= bus.req_rsrc;
            ra2_r   <= bus.req_rdest;
            wb_r    <= bus.req_wb;
            state_r <= S_READ;
          end
        end
        S_READ: begin
          // rd2 belongs to Rdest (operand A), rd1 to Rsrc (operand B)
          exe_a_r     <= bus.rd2;
          exe_b_r     <= operand_b_s;
          exe_valid_r <= 1'b1;
          state_r     <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.exe_ready) begin
            exe_valid_r <= 1'b0;
            state_r     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.res_valid) begin
            wd_r <= bus.res_data;
            if (wb_r && (ra2_r != REGBITS'(REG_ZERO))) begin
              regwrite_r <= 1'b1;
              state_r    <= S_WB;
            end else begin
              done_r  <= 1'b1;
              state_r <= S_IDLE;
            end
          end
        end
        S_WB: begin
          done_r  <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          exe_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_r == S_IDLE);
  assign bus.ra1       = ra1_r;
  assign bus.ra2       = ra2_r;
  assign bus.regwrite  = regwrite_r;
  assign bus.wd        = wd_r;
  assign bus.exe_valid = exe_valid_r;
  assign bus.exe_a     = exe_a_r;
  assign bus.exe_b     = exe_b_r;
  assign bus.done      = done_r;

endmodule
